// File: rtl/systolic_gemm_engine.sv
// Output-stationary systolic GEMM engine.
// Each PE (r,c) accumulates the dot product of activation lane r and weight lane c
// over k_len accepted beats. Activations move right and weights move down, one PE per
// array step. Once the array has flushed, the finished rows are streamed out one at a time.
//
// Handshakes (valid/ready): a beat transfers on a rising edge where valid and ready
// are both high. The producer holds its payload stable while valid is high and ready
// is low. Neither side lets valid wait on ready.
module systolic_gemm_engine #(
  parameter int PE_ROW_NUM = 4,
  parameter int PE_COL_NUM = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_K      = 256,
  localparam int K_W       = $clog2(MAX_K + 1),
  localparam int RW        = (PE_ROW_NUM > 1) ? $clog2(PE_ROW_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [K_W-1:0]                   k_len,
  output logic                             busy,
  output logic                             cal_done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PE_ROW_NUM*DATA_WIDTH-1:0] i_data,
  input  logic [PE_COL_NUM*DATA_WIDTH-1:0] w_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [PE_COL_NUM*ACC_WIDTH-1:0]  res_data,
  output logic [RW-1:0]                    res_row,
  output logic                             res_last,
  output logic [2:0]                       dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam int FW = $clog2(PE_ROW_NUM + PE_COL_NUM);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PE_ROW_NUM + PE_COL_NUM - 2);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [K_W-1:0] k_len_q;
  logic [K_W-1:0] k_cnt;
  logic [FW-1:0]  flush_cnt;

  logic start_acc, beat_acc, advance, last_beat, flush_end, last_hs;
  logic [PE_ROW_NUM*DW-1:0] feed_i;
  logic [PE_COL_NUM*DW-1:0] feed_w;

  logic signed [DW-1:0]        sk_i  [PE_ROW_NUM][PE_ROW_NUM];
  logic signed [DW-1:0]        sk_w  [PE_COL_NUM][PE_COL_NUM];
  logic signed [DW-1:0]        i_sk  [PE_ROW_NUM];
  logic signed [DW-1:0]        w_sk  [PE_COL_NUM];
  logic signed [DW-1:0]        a_in  [PE_ROW_NUM][PE_COL_NUM];
  logic signed [DW-1:0]        b_in  [PE_ROW_NUM][PE_COL_NUM];
  logic signed [DW-1:0]        a_reg [PE_ROW_NUM][PE_COL_NUM];
  logic signed [DW-1:0]        b_reg [PE_ROW_NUM][PE_COL_NUM];
  logic signed [2*DW-1:0]      prod  [PE_ROW_NUM][PE_COL_NUM];
  logic signed [ACC_WIDTH-1:0] acc   [PE_ROW_NUM][PE_COL_NUM];
  logic [PE_COL_NUM*ACC_WIDTH-1:0] row_vec [PE_ROW_NUM];
  logic [RW-1:0] next_row;

  assign start_acc = (state == IDLE) && start;
  assign beat_acc  = (state == LOAD) && in_valid;
  assign advance   = beat_acc || (state == FLUSH);
  assign last_beat = beat_acc && (k_cnt == k_len_q - K_W'(1));
  assign flush_end = (state == FLUSH) && (flush_cnt == FLUSH_LAST);
  assign last_hs   = res_valid && res_ready && res_last;
  assign feed_i    = (state == LOAD) ? i_data : '0;
  assign feed_w    = (state == LOAD) ? w_data : '0;
  assign next_row  = res_row + RW'(1);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    in_ready = 1'b0;
    cal_done = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = (k_len == '0) ? DRAIN : LOAD;
      LOAD:    begin
                 busy = 1'b1;
                 in_ready = 1'b1;
                 if (last_beat) state_nx = FLUSH;
               end
      FLUSH:   begin
                 busy = 1'b1;
                 if (flush_end) state_nx = DRAIN;
               end
      DRAIN:   begin
                 busy = 1'b1;
                 if (last_hs) state_nx = DONE;
               end
      DONE:    begin
                 busy = 1'b1;
                 cal_done = 1'b1;
                 state_nx = IDLE;
               end
      default: state_nx = IDLE;
    endcase
  end

  // Job length latch, accepted-beat counter and flush-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q   <= '0;
      k_cnt     <= '0;
      flush_cnt <= '0;
    end else begin
      if (start_acc) begin
        k_len_q <= k_len;
        k_cnt   <= '0;
      end else if (beat_acc) begin
        k_cnt <= k_cnt + K_W'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else                flush_cnt <= '0;
    end
  end

  // Input skew delay lines: lane n is read from stage n-1, giving an n-step delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || start_acc) begin
      for (int r = 0; r < PE_ROW_NUM; r++)
        for (int s = 0; s < PE_ROW_NUM; s++) sk_i[r][s] <= '0;
      for (int c = 0; c < PE_COL_NUM; c++)
        for (int s = 0; s < PE_COL_NUM; s++) sk_w[c][s] <= '0;
    end else if (advance) begin
      for (int r = 0; r < PE_ROW_NUM; r++) begin
        sk_i[r][0] <= feed_i[r*DW +: DW];
        for (int s = 1; s < PE_ROW_NUM; s++) sk_i[r][s] <= sk_i[r][s-1];
      end
      for (int c = 0; c < PE_COL_NUM; c++) begin
        sk_w[c][0] <= feed_w[c*DW +: DW];
        for (int s = 1; s < PE_COL_NUM; s++) sk_w[c][s] <= sk_w[c][s-1];
      end
    end
  end

  // Array operand routing and the full-width signed products
  always_comb begin
    i_sk[0] = feed_i[0 +: DW];
    for (int r = 1; r < PE_ROW_NUM; r++) i_sk[r] = sk_i[r][r-1];
    w_sk[0] = feed_w[0 +: DW];
    for (int c = 1; c < PE_COL_NUM; c++) w_sk[c] = sk_w[c][c-1];
    for (int r = 0; r < PE_ROW_NUM; r++) begin
      a_in[r][0] = i_sk[r];
      for (int c = 1; c < PE_COL_NUM; c++) a_in[r][c] = a_reg[r][c-1];
    end
    for (int c = 0; c < PE_COL_NUM; c++) begin
      b_in[0][c] = w_sk[c];
      for (int r = 1; r < PE_ROW_NUM; r++) b_in[r][c] = b_reg[r-1][c];
    end
    for (int r = 0; r < PE_ROW_NUM; r++)
      for (int c = 0; c < PE_COL_NUM; c++) prod[r][c] = a_in[r][c] * b_in[r][c];
  end

  // PE registers: pass operands onward and accumulate modulo 2^ACC_WIDTH, only on array steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || start_acc) begin
      for (int r = 0; r < PE_ROW_NUM; r++)
        for (int c = 0; c < PE_COL_NUM; c++) begin
          a_reg[r][c] <= '0;
          b_reg[r][c] <= '0;
          acc[r][c]   <= '0;
        end
    end else if (advance) begin
      for (int r = 0; r < PE_ROW_NUM; r++)
        for (int c = 0; c < PE_COL_NUM; c++) begin
          a_reg[r][c] <= a_in[r][c];
          b_reg[r][c] <= b_in[r][c];
          acc[r][c]   <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
        end
    end
  end

  // Pack each accumulator row into a result-stream word
  always_comb begin
    for (int r = 0; r < PE_ROW_NUM; r++) begin
      row_vec[r] = '0;
      for (int c = 0; c < PE_COL_NUM; c++) row_vec[r][c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
    end
  end

  // Result register: load row 0 on entering DRAIN, step to the next row only on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_last  <= 1'b0;
    end else if (state == DRAIN) begin
      if (!res_valid) begin
        res_valid <= 1'b1;
        res_data  <= row_vec[0];
        res_row   <= '0;
        res_last  <= (PE_ROW_NUM == 1);
      end else if (res_ready) begin
        if (res_last) begin
          res_valid <= 1'b0;
          res_data  <= '0;
          res_row   <= '0;
          res_last  <= 1'b0;
        end else begin
          res_data  <= row_vec[next_row];
          res_row   <= next_row;
          res_last  <= (next_row == RW'(PE_ROW_NUM - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Directed bench for systolic_gemm_engine (4x4, DW=16, ACC=40).
// Expected rows are pushed into exp_q as each job is issued; a negedge monitor pops
// and compares every result handshake, and also checks hold stability and the cal_done pulse.
module tb_systolic_gemm_engine;

  localparam int SBW = 1 + 2 + 4 * 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [8:0]   k_len;
  logic         busy;
  logic         cal_done;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  i_data;
  logic [63:0]  w_data;
  logic         res_valid;
  logic         res_ready;
  logic [159:0] res_data;
  logic [1:0]   res_row;
  logic         res_last;
  logic [2:0]   dbg_state;

  systolic_gemm_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .cal_done(cal_done), .in_valid(in_valid), .in_ready(in_ready),
    .i_data(i_data), .w_data(w_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_last(res_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [SBW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int acc_base = 0;
  int done_cnt = 0;
  int done_base = 0;
  int t0 = 0;
  int first_cyc = 0;
  bit first_seen = 1'b1;
  bit cal_pending = 1'b0;
  bit hold_vld = 1'b0;
  bit in_ready_seen = 1'b0;
  logic [SBW-1:0] hold_val;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic push_row(input int r, input logic [39:0] e0, input logic [39:0] e1,
                          input logic [39:0] e2, input logic [39:0] e3);
    exp_q.push_back({(r == 3), 2'(r), e3, e2, e1, e0});
  endtask

  // Input beats are driven at posedge+1, so at negedge this predicts the next accept
  always @(negedge clk) if (in_valid && in_ready) acc_cnt++;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] cur;
    logic [SBW-1:0] e;
    cur = {res_last, res_row, res_data};
    if (in_ready) in_ready_seen = 1'b1;
    if (res_valid && !first_seen) begin
      first_seen = 1'b1;
      first_cyc = cyc;
    end
    if (hold_vld) chk("hold_stable", 200'({res_valid, cur}), 200'({1'b1, hold_val}));
    if (rst_n && (cal_pending || cal_done)) chk("cal_done_pulse", 200'(cal_done), 200'(cal_pending));
    cal_pending = 1'b0;
    if (cal_done) done_cnt++;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_row: got %h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        chk("row", 200'(cur), 200'(e));
      end
      cal_pending = res_last;
    end
    hold_vld = res_valid && !res_ready;
    hold_val = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input int k, input logic [63:0] iv, input logic [63:0] wv,
                         input int gap, input int nb);
    int g;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 9'(k);
    i_data = iv;
    w_data = wv;
    in_valid = 1'b1;
    acc_base = acc_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    t0 = cyc;
    first_seen = 1'b0;
    start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      g = 0;
      while (acc_cnt < acc_base + b + 1 && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      if (acc_cnt < acc_base + b + 1) timeout_fail("beat_accept");
      if (gap > 0 && b < nb - 1) begin
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int nb);
    int g;
    g = 0;
    while (done_cnt == done_base && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (done_cnt == done_base) timeout_fail("cal_done_wait");
    in_valid = 1'b0;
    chk("beats_consumed", 200'(acc_cnt - acc_base), 200'(nb));
    chk("rows_all_seen", 200'(exp_q.size()), 200'd0);
  endtask

  task automatic wait_row(input int row);
    int g;
    g = 0;
    while (!(res_valid && res_row == 2'(row)) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!(res_valid && res_row == 2'(row))) timeout_fail("wait_row");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    i_data = '0;
    w_data = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 200'({busy, cal_done, in_ready, res_valid, res_last, res_row, res_data}), 200'd0);
    chk("reset_state", 200'(dbg_state), 200'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // K=1, i=[1,2,3,4], w=[5,6,7,8]; also the first-result latency with no gaps
    for (int r = 0; r < 4; r++) push_row(r, 40'(5 * (r + 1)), 40'(6 * (r + 1)), 40'(7 * (r + 1)), 40'(8 * (r + 1)));
    run_job(1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 0, 1);
    wait_done(1);
    chk("first_result_latency", 200'(first_cyc - t0), 200'd9);

    // K=3 ones x twos, gap-free then with two idle cycles between beats: all elements 6
    for (int r = 0; r < 4; r++) push_row(r, 40'd6, 40'd6, 40'd6, 40'd6);
    run_job(3, {4{16'd1}}, {4{16'd2}}, 0, 3);
    wait_done(3);
    chk("latency_k3", 200'(first_cyc - t0), 200'd11);
    for (int r = 0; r < 4; r++) push_row(r, 40'd6, 40'd6, 40'd6, 40'd6);
    run_job(3, {4{16'd1}}, {4{16'd2}}, 2, 3);
    wait_done(3);

    // Signed: K=2, -3 * 7 twice = -42
    for (int r = 0; r < 4; r++) push_row(r, 40'hFFFFFFFFD6, 40'hFFFFFFFFD6, 40'hFFFFFFFFD6, 40'hFFFFFFFFD6);
    run_job(2, {4{16'hFFFD}}, {4{16'd7}}, 0, 2);
    wait_done(2);

    // Backpressure on row 1; K=2, i=[1,2,3,4], w=[1,-1,2,3]
    push_row(0, 40'd2, -40'sd2, 40'd4,  40'd6);
    push_row(1, 40'd4, -40'sd4, 40'd8,  40'd12);
    push_row(2, 40'd6, -40'sd6, 40'd12, 40'd18);
    push_row(3, 40'd8, -40'sd8, 40'd16, 40'd24);
    run_job(2, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd3, 16'd2, 16'hFFFF, 16'd1}, 0, 2);
    wait_row(1);
    res_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("stalled_row_index", 200'({res_valid, res_row}), 200'({1'b1, 2'd1}));
    res_ready = 1'b1;
    wait_done(2);

    // k_len = 0: four zero rows, in_ready never high, a start during DRAIN is ignored
    for (int r = 0; r < 4; r++) push_row(r, 40'd0, 40'd0, 40'd0, 40'd0);
    in_ready_seen = 1'b0;
    run_job(0, {4{16'd3}}, {4{16'd3}}, 0, 0);
    wait_row(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);
    repeat (10) begin @(posedge clk); #1; end
    chk("k0_no_in_ready", 200'(in_ready_seen), 200'd0);
    chk("k0_idle_after", 200'({busy, res_valid}), 200'd0);

    // Reset in LOAD after 2 of 3 beats, then a clean K=1 job
    run_job(3, {4{16'd9}}, {4{16'd9}}, 0, 2);
    chk("mid_job_in_load", 200'({busy, in_ready}), 200'({1'b1, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("mid_job_reset_outputs", 200'({busy, cal_done, in_ready, res_valid, res_last, res_row, res_data}), 200'd0);
    chk("mid_job_reset_state", 200'(dbg_state), 200'd0);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_reset_idle", 200'({busy, res_valid, in_ready}), 200'd0);
    push_row(0, 40'd4, 40'd8, 40'd12, 40'd16);
    push_row(1, 40'd3, 40'd6, 40'd9,  40'd12);
    push_row(2, 40'd2, 40'd4, 40'd6,  40'd8);
    push_row(3, 40'd1, 40'd2, 40'd3,  40'd4);
    run_job(1, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd4, 16'd3, 16'd2, 16'd1}, 0, 1);
    wait_done(1);

    repeat (3) @(posedge clk);
    chk("queue_empty", 200'(exp_q.size()), 200'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so a stuck DUT cannot hang the run
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before %0d cycles", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_gemm_engine.md
SYSTOLIC_GEMM_ENGINE -- requirements
Module: systolic_gemm_engine

Interface
REQ-001 SHALL have parameter PE_ROW_NUM, default 4: PE array rows, one per input-activation lane.
REQ-002 SHALL have parameter PE_COL_NUM, default 4: PE array columns, one per weight lane.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 40: signed accumulator width, at least 2*DATA_WIDTH.
REQ-005 SHALL have parameter MAX_K, default 256: maximum runtime reduction length. K_W = clog2(MAX_K+1).
REQ-006 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have these control ports:
- start  in  1  job request.
- k_len  in  K_W  reduction length, sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- cal_done  out  1  one-cycle pulse at job end.
REQ-008 SHALL have these input-stream ports:
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- i_data  in  PE_ROW_NUM*DATA_WIDTH  activations; lane r at bits [r*DW +: DW].
- w_data  in  PE_COL_NUM*DATA_WIDTH  weights; lane c at bits [c*DW +: DW].
REQ-009 SHALL have these result-stream ports:
- res_valid  out  1  result row valid.
- res_ready  in  1  downstream ready.
- res_data  out  PE_COL_NUM*ACC_WIDTH  one result row; column c at bits [c*ACC +: ACC].
- res_row  out  clog2(PE_ROW_NUM)  index of the row on res_data.
- res_last  out  1  high on the final row.

Function
REQ-010 SHALL compute an output-stationary product: C[r][c] = sum over k < k_len of i_data[r](k) * w_data[c](k), where k is the accepted-beat index.
REQ-011 SHALL treat operands as signed, form full 2*DW products, sign-extend them to ACC_WIDTH, and accumulate modulo 2^ACC_WIDTH with no saturation.
REQ-012 SHALL use an FSM with states IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-013 SHALL, in IDLE, accept start: clear all accumulators, latch k_len, and go to LOAD. If k_len is 0, it SHALL go directly to DRAIN.
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 SHALL drive in_ready high only in LOAD.
REQ-016 SHALL, after exactly k_len accepted beats, go to FLUSH. Beats offered outside LOAD SHALL NOT be consumed.
REQ-017 SHALL skew row lane r by r array steps and column lane c by c array steps before they enter the array.
REQ-018 SHALL advance the array (skew registers, operand pipeline, MACs) only on an accepted beat or on a FLUSH cycle. In all other cycles the array SHALL hold, so gaps in in_valid do not change results.
REQ-019 SHALL stay in FLUSH for exactly PE_ROW_NUM+PE_COL_NUM-1 cycles, injecting zero operands, then go to DRAIN.
REQ-020 SHALL, in DRAIN, present rows 0..PE_ROW_NUM-1 in order with res_valid high.
REQ-021 SHALL hold res_data, res_row and res_last stable while res_valid is high and res_ready is low. A row SHALL advance only on the res_valid and res_ready handshake.
REQ-022 SHALL assert res_last only together with res_row = PE_ROW_NUM-1.
REQ-023 SHALL, on the final row handshake, go to DONE. DONE SHALL pulse cal_done for one cycle and then return to IDLE.
REQ-024 SHALL, with in_valid held high and res_ready held high, produce the first res_valid exactly k_len + PE_ROW_NUM + PE_COL_NUM cycles after the start-accept edge.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-job, immediately go to IDLE.
REQ-026 SHALL, under reset, clear accumulators, skew registers and counters, and drive busy, cal_done, in_ready, res_valid, res_last, res_row and res_data to 0.
REQ-027 SHALL, after reset is released, require a new start before any activity. No partial result SHALL ever be emitted.

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- K=1: i=[1,2,3,4], w=[5,6,7,8] -> row r = {5(r+1), 6(r+1), 7(r+1), 8(r+1)}; res_last on row 3; cal_done one cycle after the row-3 handshake.
- K=3 with in_valid low for 2 cycles between beats: all beats i=[1,1,1,1], w=[2,2,2,2] -> every element 6; result identical to the gap-free run.
- Signed: K=2, i lanes = 0xFFFD (-3), w lanes = 7 -> every element -42, i.e. 0xFFFFFFFFD6 at ACC 40.
- Backpressure: res_ready low for 5 cycles while row 1 is presented -> row 1 data stable throughout, no row lost or duplicated, order 0..3.
- k_len=0 -> four all-zero rows, no in_ready assertion; a start pulsed mid-DRAIN has no effect.
- rst_n low in LOAD after 2 beats -> outputs 0 immediately; a new K=1 job then yields the correct, uncontaminated result.
